tx_payload_buffer: RTL and testbench
====================================

// Module: tx_payload_buffer
// PURPOSE
//   Single-frame payload staging buffer upstream of the Ethernet TX encapsulator.
//   Collects one payload frame of bytes from the MAC user/host write interface into on-chip RAM.
//   Once the frame is complete, offers it to the encapsulator with buffer_ready.
//   Then bursts it out with read_en/data_out and signals completion with buffer_empt.
//   Both sides run on clk, the Ethernet controller clock.
// PARAMETERS
//   MAX_PAYLOAD  1500  max payload bytes per frame; longer frames are dropped
//   ADDR_W       11    RAM address width; 2**ADDR_W >= MAX_PAYLOAD required
// PORTS
//   clk            in   1   Ethernet controller clock
//   rst            in   1   reset, synchronous, active-low
//   wr_valid       in   1   user byte valid
//   wr_data        in   8   user payload byte
//   wr_last        in   1   qualifies final byte of frame (with wr_valid)
//   wr_ready       out  1   buffer accepts user byte this cycle
//   buffer_ready   out  1   complete frame stored, awaiting encapsulator
//   data_recived   in   1   encapsulator acknowledge; level or pulse
//   read_en        out  1   data_out holds a valid payload byte this cycle
//   data_out       out  8   payload byte to encapsulator, first byte first
//   buffer_empt    out  1   no unread bytes held
//   frame_len      out  16  byte count of stored frame
//   frame_drop     out  1   1-cycle pulse: oversize frame discarded
// BEHAVIOUR
//   - Reset: rst sampled low on a clk edge returns the block to S_FILL and zeroes wr_ptr/rd_ptr/len.
//     Register outputs: wr_ready=1, buffer_ready=0, read_en=0, data_out=0, buffer_empt=1, frame_len=0, frame_drop=0.
//     Reset overrides everything, including mid-fill and mid-drain; the partial frame is lost.
//     RAM contents are don't-care.
//   - All outputs are registered.
//   - A byte is accepted when wr_valid & wr_ready.
//   - States: S_FILL, S_DROP, S_READY, S_DRAIN.
//   - S_FILL (wr_ready=1):
//     - Each accepted byte is written to mem[wr_ptr], then wr_ptr++ and len++.
//     - Accepted byte with wr_last, total len <= MAX_PAYLOAD: frame_len<=len, go S_READY.
//       wr_ready=0 and buffer_ready=1 from the next cycle.
//     - Accepted byte number MAX_PAYLOAD+1 without wr_last: go S_DROP. Nothing is written.
//     - Accepted byte number MAX_PAYLOAD+1 with wr_last: pulse frame_drop, reset wr_ptr/len, stay in S_FILL.
//   - S_DROP (wr_ready=1): bytes are accepted and discarded.
//     - On accepted wr_last: pulse frame_drop next cycle, reset wr_ptr/len, go S_FILL.
//   - S_READY (wr_ready=0, buffer_ready=1, buffer_empt=0):
//     - Waits indefinitely. data_recived is sampled only here.
//     - data_recived=1 at edge N: buffer_ready=0 from N+1, rd_ptr=0, go S_DRAIN.
//   - S_DRAIN: synchronous RAM read, 1-cycle latency.
//     - read_en=1 with data_out=mem[0..frame_len-1] on consecutive cycles N+2 .. N+1+frame_len.
//     - No gaps, no backpressure.
//     - At N+2+frame_len: read_en=0, data_out=0, buffer_empt=1, wr_ptr/len=0, wr_ready=1, go S_FILL.
//   - buffer_empt=0 from the cycle after the frame completes (S_READY entry) until drain end.
//     It stays 1 while filling.
//   - wr_valid in S_READY/S_DRAIN is ignored; wr_ready=0, so no byte is lost.
//   - data_recived held high continuously: the next completed frame drains immediately after S_READY entry.
//     buffer_ready is still high for exactly 1 cycle.
//   - len/frame_len are 16 bits and never wrap, because the overflow check saturates at MAX_PAYLOAD+1.
//   - A 1-byte frame is legal: wr_valid & wr_last on the first byte.
// TESTING
//   - Reset: hold rst=0 3 cycles -> wr_ready=1, buffer_ready=0, read_en=0, buffer_empt=1, frame_len=0.
//   - 46-byte frame (0x00..0x2D), data_recived pulse at N -> buffer_ready 1, frame_len=46;
//     read_en high N+2..N+47, data_out 0x00..0x2D in order; buffer_empt=1 at N+48.
//   - 1501-byte frame with wr_last on last byte -> frame_drop one pulse, buffer_ready never 1;
//     a following 60-byte frame is delivered intact.
//   - 1500-byte frame -> accepted, frame_len=1500; all 1500 bytes drained, last byte = byte 1499.
//   - wr_valid held high during S_READY/S_DRAIN -> wr_ready=0, no RAM writes; second frame accepted only after buffer_empt=1.
//   - rst=0 mid-drain after 10 bytes -> next cycle read_en=0, buffer_empt=1, S_FILL; a new 1-byte frame drains correctly.

Source files
------------

// File: rtl/tx_payload_buffer.sv
// Single-frame payload staging buffer: fills one frame from the host write side,
// then drains it to the Ethernet TX encapsulator. Oversize frames are discarded.
module tx_payload_buffer #(
    parameter int MAX_PAYLOAD = 1500,
    parameter int ADDR_W      = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    input  logic        wr_last,
    output logic        wr_ready,
    output logic        buffer_ready,
    input  logic        data_recived,
    output logic        read_en,
    output logic [7:0]  data_out,
    output logic        buffer_empt,
    output logic [15:0] frame_len,
    output logic        frame_drop
);

    typedef enum logic [1:0] {S_FILL, S_DROP, S_READY, S_DRAIN} state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [15:0]       len;
    logic [7:0]        mem [0:(1<<ADDR_W)-1];

    logic accept;
    logic mem_we;

    assign accept = wr_valid & wr_ready;
    // The byte that would exceed MAX_PAYLOAD is never stored.
    assign mem_we = (state == S_FILL) && accept && (len != MAX_LEN);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_FILL;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            len          <= '0;
            wr_ready     <= 1'b1;
            buffer_ready <= 1'b0;
            read_en      <= 1'b0;
            data_out     <= '0;
            buffer_empt  <= 1'b1;
            frame_len    <= '0;
            frame_drop   <= 1'b0;
        end else begin
            frame_drop <= 1'b0;
            case (state)
                S_FILL: begin
                    if (accept) begin
                        if (len == MAX_LEN) begin
                            if (wr_last) begin
                                frame_drop <= 1'b1;
                                wr_ptr     <= '0;
                                len        <= '0;
                            end else begin
                                state <= S_DROP;
                            end
                        end else begin
                            wr_ptr <= wr_ptr + ADDR_W'(1);
                            len    <= len + 16'd1;
                            if (wr_last) begin
                                frame_len    <= len + 16'd1;
                                state        <= S_READY;
                                wr_ready     <= 1'b0;
                                buffer_ready <= 1'b1;
                                buffer_empt  <= 1'b0;
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (accept && wr_last) begin
                        frame_drop <= 1'b1;
                        wr_ptr     <= '0;
                        len        <= '0;
                        state      <= S_FILL;
                    end
                end
                S_READY: begin
                    if (data_recived) begin
                        buffer_ready <= 1'b0;
                        rd_ptr       <= '0;
                        state        <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // rd_ptr counts reads issued; data_out lags it by one cycle.
                    if (16'(rd_ptr) == frame_len) begin
                        read_en     <= 1'b0;
                        data_out    <= '0;
                        buffer_empt <= 1'b1;
                        wr_ptr      <= '0;
                        len         <= '0;
                        wr_ready    <= 1'b1;
                        state       <= S_FILL;
                    end else begin
                        read_en  <= 1'b1;
                        data_out <= mem[rd_ptr];
                        rd_ptr   <= rd_ptr + ADDR_W'(1);
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_payload_buffer.sv
// Randomized self-checking bench for tx_payload_buffer against a frame-level queue model.
module tb_tx_payload_buffer;

    localparam int MAX_PAYLOAD = 1500;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_last = 1'b0;
    logic        data_recived = 1'b0;
    logic        wr_ready;
    logic        buffer_ready;
    logic        read_en;
    logic [7:0]  data_out;
    logic        buffer_empt;
    logic [15:0] frame_len;
    logic        frame_drop;

    int checks = 0;
    int errors = 0;
    logic [7:0] frame_q[$];

    tx_payload_buffer #(.MAX_PAYLOAD(MAX_PAYLOAD), .ADDR_W(11)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_last      (wr_last),
        .wr_ready     (wr_ready),
        .buffer_ready (buffer_ready),
        .data_recived (data_recived),
        .read_en      (read_en),
        .data_out     (data_out),
        .buffer_empt  (buffer_empt),
        .frame_len    (frame_len),
        .frame_drop   (frame_drop)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_frame(input int n, input bit ramp);
        frame_q.delete();
        for (int i = 0; i < n; i++) begin
            frame_q.push_back(ramp ? 8'(i) : 8'($urandom));
        end
    endtask

    // Called at a negedge with the DUT filling; returns at a negedge.
    task automatic send_frame(input bit gaps);
        int n;
        n = frame_q.size();
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                wr_valid = 1'b0;
                wr_last  = 1'b0;
                @(negedge clk);
            end
            check_val("wr_ready_fill", 32'(wr_ready), 32'd1);
            check_val("no_drop_mid", 32'(frame_drop), 32'd0);
            wr_valid = 1'b1;
            wr_data  = frame_q[i];
            wr_last  = (i == n - 1);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        if (n > MAX_PAYLOAD) begin
            check_val("drop_pulse", 32'(frame_drop), 32'd1);
            check_val("drop_no_ready", 32'(buffer_ready), 32'd0);
            check_val("drop_empt", 32'(buffer_empt), 32'd1);
            check_val("drop_wr_ready", 32'(wr_ready), 32'd1);
            @(negedge clk);
            check_val("drop_pulse_end", 32'(frame_drop), 32'd0);
            check_val("drop_no_ready2", 32'(buffer_ready), 32'd0);
        end else begin
            check_val("buffer_ready", 32'(buffer_ready), 32'd1);
            check_val("frame_len", 32'(frame_len), 32'(n));
            check_val("empt_after_fill", 32'(buffer_empt), 32'd0);
            check_val("wr_ready_ready", 32'(wr_ready), 32'd0);
            check_val("no_drop_ok", 32'(frame_drop), 32'd0);
        end
    endtask

    // Acknowledge after wait_cyc cycles in S_READY, then expect the whole queue back.
    task automatic drain(input int wait_cyc, input bit junk, input bit hold, input int abort_after);
        for (int w = 0; w < wait_cyc; w++) begin
            wr_valid = junk;
            wr_data  = 8'($urandom);
            @(negedge clk);
            check_val("ready_wait", 32'(buffer_ready), 32'd1);
            check_val("ready_wr_ready", 32'(wr_ready), 32'd0);
            check_val("ready_read_en", 32'(read_en), 32'd0);
        end
        data_recived = 1'b1;
        @(negedge clk);
        check_val("ack_ready_low", 32'(buffer_ready), 32'd0);
        check_val("ack_read_en", 32'(read_en), 32'd0);
        if (!hold) data_recived = 1'b0;
        for (int k = 0; k < frame_q.size(); k++) begin
            if (k == abort_after) begin
                wr_valid = 1'b0;
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                check_val("rst_read_en", 32'(read_en), 32'd0);
                check_val("rst_empt", 32'(buffer_empt), 32'd1);
                check_val("rst_wr_ready", 32'(wr_ready), 32'd1);
                check_val("rst_buffer_ready", 32'(buffer_ready), 32'd0);
                check_val("rst_frame_len", 32'(frame_len), 32'd0);
                check_val("rst_data_out", 32'(data_out), 32'd0);
                return;
            end
            wr_valid = junk;
            wr_data  = 8'($urandom);
            @(negedge clk);
            check_val("drain_read_en", 32'(read_en), 32'd1);
            check_val("drain_data", 32'(data_out), 32'(frame_q[k]));
            check_val("drain_wr_ready", 32'(wr_ready), 32'd0);
            check_val("drain_empt", 32'(buffer_empt), 32'd0);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        check_val("end_read_en", 32'(read_en), 32'd0);
        check_val("end_data_out", 32'(data_out), 32'd0);
        check_val("end_empt", 32'(buffer_empt), 32'd1);
        check_val("end_wr_ready", 32'(wr_ready), 32'd1);
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_wr_ready", 32'(wr_ready), 32'd1);
        check_val("reset_buffer_ready", 32'(buffer_ready), 32'd0);
        check_val("reset_read_en", 32'(read_en), 32'd0);
        check_val("reset_empt", 32'(buffer_empt), 32'd1);
        check_val("reset_frame_len", 32'(frame_len), 32'd0);
        check_val("reset_data_out", 32'(data_out), 32'd0);
        check_val("reset_frame_drop", 32'(frame_drop), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        build_frame(46, 1'b1);
        send_frame(1'b0);
        drain(2, 1'b0, 1'b0, -1);

        // Oversize with wr_last exactly on byte 1501, then a normal frame.
        build_frame(1501, 1'b0);
        send_frame(1'b1);
        build_frame(60, 1'b0);
        send_frame(1'b1);
        drain(0, 1'b0, 1'b0, -1);

        // Oversize that runs on past byte 1501.
        build_frame(1600, 1'b0);
        send_frame(1'b0);

        build_frame(MAX_PAYLOAD, 1'b0);
        send_frame(1'b0);
        drain(1, 1'b0, 1'b0, -1);

        // Writes presented while the frame is held or draining must be ignored.
        build_frame(30, 1'b0);
        send_frame(1'b0);
        drain(3, 1'b1, 1'b0, -1);
        build_frame(20, 1'b0);
        send_frame(1'b0);
        drain(0, 1'b0, 1'b0, -1);

        // Acknowledge held high across frames.
        data_recived = 1'b1;
        build_frame(5, 1'b0);
        send_frame(1'b0);
        drain(0, 1'b0, 1'b1, -1);
        build_frame(1, 1'b0);
        send_frame(1'b0);
        drain(0, 1'b0, 1'b1, -1);
        data_recived = 1'b0;

        for (int f = 0; f < 8; f++) begin
            build_frame($urandom_range(1, 80), 1'b0);
            send_frame(1'b1);
            drain($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0, -1);
        end

        build_frame(25, 1'b0);
        send_frame(1'b0);
        drain(0, 1'b0, 1'b0, 10);
        build_frame(1, 1'b0);
        send_frame(1'b0);
        drain(0, 1'b0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
